// File: rtl/tcb_lib_register_response_if.sv
// TCB bus bundle: request fields flow manager -> subordinate, response fields flow back.
interface tcb_lib_register_response_if #(
   parameter int unsigned ADR = 32,
   parameter int unsigned DAT = 32
);
   localparam int unsigned BYT = DAT/8;

   logic           vld;
   logic           rdy;
   logic           wen;
   logic [ADR-1:0] adr;
   logic [BYT-1:0] byt;
   logic [DAT-1:0] wdt;
   logic [DAT-1:0] rdt;
   logic           sts;

   modport master (output vld, wen, adr, byt, wdt, input  rdy, rdt, sts);
   modport slave  (input  vld, wen, adr, byt, wdt, output rdy, rdt, sts);
endinterface

// File: rtl/tcb_lib_register_response.sv
// Pass-through TCB stage that registers the response path: requests forward combinationally,
// the response is captured DLY cycles after the transfer and presented one cycle later upstream.
module tcb_lib_register_response #(
   parameter int unsigned ADR = 32,
   parameter int unsigned DAT = 32,
   parameter int unsigned DLY = 1
)(
   input  logic clk,
   input  logic rst,
   tcb_lib_register_response_if.slave  sub,
   tcb_lib_register_response_if.master man
);
   localparam int unsigned BYT = DAT/8;

   logic [ADR-1:0] adr;
   logic [BYT-1:0] byt;
   logic           trn;
   logic           cap;
   logic [DAT-1:0] rdt_reg;
   logic           sts_reg;

   assign adr     = sub.adr;
   assign byt     = sub.byt;
   assign man.vld = sub.vld;
   assign man.wen = sub.wen;
   assign man.adr = adr;
   assign man.byt = byt;
   assign man.wdt = sub.wdt;
   assign sub.rdy = man.rdy;

   assign trn = sub.vld & man.rdy;

   generate
      if (DLY == 0) begin : g_dly0
         // Subordinate answers in the transfer cycle itself.
         assign cap = trn;
      end else begin : g_dly
         logic [DLY-1:0] flg_reg;
         always_ff @(posedge clk) begin
            if (!rst) begin
               flg_reg <= '0;
            end else begin
               flg_reg[0] <= trn;
               for (int i = 1; i < DLY; i++) begin
                  flg_reg[i] <= flg_reg[i-1];
               end
            end
         end
         assign cap = flg_reg[DLY-1];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst) begin
         rdt_reg <= '0;
         sts_reg <= 1'b0;
      end else if (cap) begin
         rdt_reg <= man.rdt;
         sts_reg <= man.sts;
      end
   end

   assign sub.rdt = rdt_reg;
   assign sub.sts = sts_reg;
endmodule

// File: tb/tb_tcb_lib_register_response.sv
// Drives one request stream into a DLY=1 and a DLY=0 instance and scoreboards both response paths.
`timescale 1ns/1ps
module tb_tcb_lib_register_response;
   typedef struct {
      bit          rst;
      bit          vld;
      bit          wen;
      logic [31:0] adr;
      logic [3:0]  byt;
      logic [31:0] wdt;
      bit          rdy;
      logic [31:0] rdt;   // response the subordinate returns for this transfer
      bit          sts;
   } vec_t;

   typedef struct {
      logic [31:0] rdt;
      logic        sts;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   tcb_lib_register_response_if #(.ADR(32), .DAT(32)) s1();
   tcb_lib_register_response_if #(.ADR(32), .DAT(32)) m1();
   tcb_lib_register_response_if #(.ADR(32), .DAT(32)) s0();
   tcb_lib_register_response_if #(.ADR(32), .DAT(32)) m0();

   tcb_lib_register_response #(.ADR(32), .DAT(32), .DLY(1)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .sub (s1),
      .man (m1)
   );

   tcb_lib_register_response #(.ADR(32), .DAT(32), .DLY(0)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .sub (s0),
      .man (m0)
   );

   exp_t        q1[$];
   exp_t        q0[$];
   logic [32:0] held1 = '0;
   logic [32:0] held0 = '0;
   int          cyc    = 0;
   int          passed = 0;
   int          total  = 0;
   bit          prv_trn = 1'b0;
   logic [31:0] prv_rdt = '0;
   bit          prv_sts = 1'b0;
   vec_t        tbl[$];

   function automatic vec_t mk(bit r, bit vld, bit wen, logic [31:0] adr, logic [3:0] byt,
                               logic [31:0] wdt, bit rdy, logic [31:0] rdt, bit sts);
      vec_t v;
      v.rst = r; v.vld = vld; v.wen = wen; v.adr = adr; v.byt = byt;
      v.wdt = wdt; v.rdy = rdy; v.rdt = rdt; v.sts = sts;
      return v;
   endfunction

   function automatic vec_t idle(bit r);
      return mk(r, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0);
   endfunction

   task automatic check(string name, logic [127:0] act, logic [127:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      else
         passed++;
   endtask

   task automatic rsp_check(int d, logic [32:0] act);
      exp_t        e;
      logic [32:0] exp;
      if (d == 0) begin
         if (q0.size() > 0 && q0[0].due == cyc) begin
            e = q0.pop_front();
            held0 = {e.sts, e.rdt};
            $display("txn dly0 cycle %0d rdt=%h sts=%0d", cyc, e.rdt, e.sts);
         end
         exp = held0;
      end else begin
         if (q1.size() > 0 && q1[0].due == cyc) begin
            e = q1.pop_front();
            held1 = {e.sts, e.rdt};
            $display("txn dly1 cycle %0d rdt=%h sts=%0d", cyc, e.rdt, e.sts);
         end
         exp = held1;
      end
      check(d == 0 ? "rsp_dly0" : "rsp_dly1", 128'(act), 128'(exp));
   endtask

   task automatic run(vec_t v);
      bit          trn;
      logic [31:0] junk;
      exp_t        e;
      @(posedge clk);
      #1;
      cyc++;
      junk = 32'hBAD0_0000 ^ 32'(cyc);
      rst = v.rst;
      s1.vld = v.vld; s1.wen = v.wen; s1.adr = v.adr; s1.byt = v.byt; s1.wdt = v.wdt;
      s0.vld = v.vld; s0.wen = v.wen; s0.adr = v.adr; s0.byt = v.byt; s0.wdt = v.wdt;
      m1.rdy = v.rdy;
      m0.rdy = v.rdy;
      trn = v.vld & v.rdy;
      // Subordinate models: DLY=0 answers now, DLY=1 answers the previous cycle's transfer.
      m0.rdt = trn ? v.rdt : junk;
      m0.sts = trn ? v.sts : 1'b1;
      m1.rdt = prv_trn ? prv_rdt : junk;
      m1.sts = prv_trn ? prv_sts : 1'b1;
      if (trn && v.rst) begin
         e.rdt = v.rdt; e.sts = v.sts;
         e.due = cyc + 1; q0.push_back(e);
         e.due = cyc + 2; q1.push_back(e);
      end
      prv_trn = trn; prv_rdt = v.rdt; prv_sts = v.sts;
      @(negedge clk);
      check("fwd_dly1", 128'({m1.vld, m1.wen, m1.adr, m1.byt, m1.wdt, s1.rdy}),
                        128'({v.vld, v.wen, v.adr, v.byt, v.wdt, v.rdy}));
      check("fwd_dly0", 128'({m0.vld, m0.wen, m0.adr, m0.byt, m0.wdt, s0.rdy}),
                        128'({v.vld, v.wen, v.adr, v.byt, v.wdt, v.rdy}));
      rsp_check(1, {s1.sts, s1.rdt});
      rsp_check(0, {s0.sts, s0.rdt});
      // Reset seen at the coming edge drops everything still pending.
      if (!v.rst) begin
         q0.delete(); q1.delete();
         held0 = '0; held1 = '0;
      end
   endtask

   initial begin
      vec_t v;
      s1.vld = 0; s1.wen = 0; s1.adr = 0; s1.byt = 0; s1.wdt = 0;
      s0.vld = 0; s0.wen = 0; s0.adr = 0; s0.byt = 0; s0.wdt = 0;
      m1.rdy = 1; m1.rdt = 0; m1.sts = 0;
      m0.rdy = 1; m0.rdt = 0; m0.sts = 0;

      tbl.push_back(idle(1'b0));
      tbl.push_back(idle(1'b0));
      tbl.push_back(idle(1'b1));
      tbl.push_back(mk(1, 1, 1, 32'h0123_4567, 4'hF, 32'h7654_3210, 1, 32'h1111_2222, 0));
      tbl.push_back(idle(1'b1));
      tbl.push_back(idle(1'b1));
      tbl.push_back(mk(1, 1, 0, 32'h89AB_CDEF, 4'hF, 32'h0, 1, 32'hFEDC_BA98, 0));
      repeat (3) tbl.push_back(idle(1'b1));
      tbl.push_back(mk(1, 1, 1, 32'h0000_0010, 4'h3, 32'hAAAA_5555, 1, 32'h0000_0000, 0));
      tbl.push_back(mk(1, 1, 0, 32'h0000_0014, 4'hF, 32'h0, 1, 32'h1357_9BDF, 0));
      tbl.push_back(idle(1'b1));
      repeat (3) tbl.push_back(mk(1, 1, 0, 32'h0000_0020, 4'hF, 32'h0, 0, 32'hDEAD_BEEF, 1));
      tbl.push_back(mk(1, 1, 0, 32'h0000_0020, 4'hF, 32'h0, 1, 32'h2468_ACE0, 0));
      repeat (2) tbl.push_back(idle(1'b1));
      tbl.push_back(mk(1, 1, 0, 32'h0000_0030, 4'hF, 32'h0, 1, 32'h0F0F_0F0F, 1));
      repeat (2) tbl.push_back(idle(1'b1));
      tbl.push_back(mk(1, 1, 1, 32'h0000_0040, 4'h1, 32'h0000_00FF, 1, 32'h55AA_55AA, 0));
      tbl.push_back(mk(0, 1, 0, 32'h0000_0044, 4'hF, 32'h0, 1, 32'h9999_9999, 1));
      repeat (3) tbl.push_back(idle(1'b1));
      tbl.push_back(mk(1, 1, 0, 32'h0000_0050, 4'hF, 32'h0, 1, 32'h7777_8888, 1));
      repeat (2) tbl.push_back(idle(1'b1));

      for (int i = 0; i < tbl.size(); i++) run(tbl[i]);

      // Hand sequence: four back-to-back reads, then a drain.
      for (int i = 0; i < 4; i++)
         run(mk(1, 1, 0, 32'h100 + 32'(4*i), 4'hF, 32'h0, 1, 32'hC0DE_0000 + 32'(i), 1'(i & 1)));
      repeat (3) run(idle(1'b1));

      // Random traffic with backpressure and occasional reset.
      for (int i = 0; i < 300; i++) begin
         v.rst = ($urandom_range(0, 39) != 0);
         v.vld = 1'($urandom_range(0, 1));
         v.wen = 1'($urandom_range(0, 1));
         v.adr = $urandom;
         v.byt = 4'($urandom);
         v.wdt = $urandom;
         v.rdy = ($urandom_range(0, 3) != 0);
         v.rdt = $urandom;
         v.sts = 1'($urandom_range(0, 1));
         run(v);
      end
      repeat (4) run(idle(1'b1));

      check("drain", 128'(q0.size() + q1.size()), 128'(0));
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
